iu_mdu: RTL and testbench

IU_MDU -- requirements
Module: iu_mdu

---
 rtl/iu_mdu.sv | 229 ++++++++++++++++++++++
 tb/tb_iu_mdu.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : iu_mdu
// Purpose  : Iterative multiply/divide unit that owns the HI/LO registers.
//            MULT/MULTU use one radix-2 shift-add step per cycle. DIV/DIVU use
//            one restoring-division step per cycle. Each operation takes
//            exactly WIDTH cycles. Signed operations run on operand magnitudes.
//            The sign is fixed up on the final step, so no extra cycle is spent.
// Ports    : clk_i, rst_i      clock, asynchronous active-high reset
//            start_i, op_i     request and opcode (00 MULT, 01 MULTU,
//                              10 DIV, 11 DIVU), sampled with a_i/b_i
//            a_i, b_i          multiplicand/dividend, multiplier/divisor
//            cancel_i          flush: abort any operation in flight
//            whi_i, wlo_i      MTHI/MTLO write enables, data on wdata_i
//            busy_o, done_o    RUN state, one-cycle completion pulse
//            hi_o, lo_o        architectural HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module iu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    input  logic             whi_i,
    input  logic             wlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // partial product high half / remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // multiplier shift reg / dividend->quotient
    logic [WIDTH-1:0] bmag_q, bmag_d;   // |b|
    logic [WIDTH-1:0] a_q, a_d;         // original a, returned as HI on divide-by-zero
    logic             isdiv_q, isdiv_d;
    logic             negq_q, negq_d;   // negate product / quotient at the end
    logic             negr_q, negr_d;   // negate remainder at the end
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             w_accept;
    logic             w_last;
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_rem;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_acc_step, w_quo_step;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_res_hi, w_res_lo;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign w_accept = start_i && !cancel_i && (state_q != ST_RUN);
    assign w_last   = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cancel_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN:  if (w_last)  state_d = ST_DONE;
                ST_DONE: state_d = start_i ? ST_RUN : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == ST_RUN);
        done_o = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Operand preparation: signed ops run on magnitudes. The magnitude of
    // the most-negative value is the same bit pattern read as unsigned.
    // ------------------------------------------------------------------
    assign w_a_neg = ~op_i[0] & a_i[WIDTH-1];
    assign w_b_neg = ~op_i[0] & b_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a_i : a_i;
    assign w_b_mag = w_b_neg ? -b_i : b_i;

    // ------------------------------------------------------------------
    // One radix-2 step
    // ------------------------------------------------------------------
    // Multiply: conditionally add |b| into the high half, then shift the
    // (carry, acc, quo) chain right by one.
    assign w_mul_sum = quo_q[0] ? ({1'b0, acc_q} + {1'b0, bmag_q}) : {1'b0, acc_q};

    // Restoring divide: shift the next dividend bit into the remainder. The
    // remainder stays below 2*|b|, so a successful subtraction fits in WIDTH
    // bits and can be computed modulo 2^WIDTH.
    assign w_div_rem  = {acc_q, quo_q[WIDTH-1]};
    assign w_div_ge   = (w_div_rem >= {1'b0, bmag_q});
    assign w_div_diff = w_div_rem[WIDTH-1:0] - bmag_q;

    assign w_acc_step = isdiv_q ? (w_div_ge ? w_div_diff : w_div_rem[WIDTH-1:0])
                                : w_mul_sum[WIDTH:1];
    assign w_quo_step = isdiv_q ? {quo_q[WIDTH-2:0], w_div_ge}
                                : {w_mul_sum[0], quo_q[WIDTH-1:1]};

    // Final-step sign correction, applied directly to the values being loaded.
    assign w_prod     = {w_acc_step, w_quo_step};
    assign w_prod_fix = negq_q ? -w_prod : w_prod;

    always_comb begin
        w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_fix[WIDTH-1:0];
        if (isdiv_q) begin
            if (divz_q) begin
                w_res_hi = a_q;
                w_res_lo = '1;
            end else begin
                w_res_hi = negr_q ? -w_acc_step : w_acc_step;
                w_res_lo = negq_q ? -w_quo_step : w_quo_step;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        bmag_d  = bmag_q;
        a_d     = a_q;
        isdiv_d = isdiv_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (cancel_i) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d   = '0;
            acc_d   = '0;
            quo_d   = w_a_mag;
            bmag_d  = w_b_mag;
            a_d     = a_i;
            isdiv_d = op_i[1];
            negq_d  = w_a_neg ^ w_b_neg;
            negr_d  = w_a_neg;
            divz_d  = op_i[1] && (b_i == '0);
        end else if (state_q == ST_RUN) begin
            acc_d = w_acc_step;
            quo_d = w_quo_step;
            if (w_last) begin
                cnt_d = '0;
                hi_d  = w_res_hi;
                lo_d  = w_res_lo;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // MTHI/MTLO take effect outside RUN. A write in the same cycle as an
        // accepted start lands now and is later replaced by the result.
        if (!cancel_i && (state_q != ST_RUN)) begin
            if (whi_i) hi_d = wdata_i;
            if (wlo_i) lo_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            bmag_q  <= '0;
            a_q     <= '0;
            isdiv_q <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            bmag_q  <= bmag_d;
            a_q     <= a_d;
            isdiv_q <= isdiv_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_iu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iu_mdu
// Purpose  : Self-checking bench for iu_mdu. One instance is built at
//            WIDTH=32 and one at WIDTH=8, and both share the same stimulus.
//            A behavioural model predicts busy/done/hi/lo every cycle from
//            plain arithmetic plus a per-instance countdown. Directed
//            sequences pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iu_mdu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, cancel, whi, wlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;

    logic        busy32, done32, busy8, done8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int n_vec = 0;
    int n_err = 0;

    iu_mdu #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .a_i(a), .b_i(b), .cancel_i(cancel), .whi_i(whi), .wlo_i(wlo),
        .wdata_i(wdata), .busy_o(busy32), .done_o(done32),
        .hi_o(hi32), .lo_o(lo32)
    );

    iu_mdu #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .a_i(a[7:0]), .b_i(b[7:0]), .cancel_i(cancel), .whi_i(whi), .wlo_i(wlo),
        .wdata_i(wdata[7:0]), .busy_o(busy8), .done_o(done8),
        .hi_o(hi8), .lo_o(lo8)
    );

    // ---------------- behavioural model ----------------
    int          m_left [2];   // remaining RUN cycles, 0 = not running
    logic        m_done [2];
    logic [31:0] m_hi   [2];
    logic [31:0] m_lo   [2];
    logic [31:0] p_hi   [2];   // result pending for the operation in flight
    logic [31:0] p_lo   [2];

    function automatic int wid(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic void ref_calc(input int w, input logic [1:0] fop,
                                     input logic [31:0] fa, input logic [31:0] fb,
                                     output logic [31:0] rhi, output logic [31:0] rlo);
        logic [63:0] mask, ua, ub, up;
        longint      sa, sb, msb, q, r, p;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, fa} & mask;
        ub   = {32'd0, fb} & mask;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua[w-1]) sa = sa - longint'(64'd1 << w);
        if (ub[w-1]) sb = sb - longint'(64'd1 << w);
        msb  = longint'(64'd1 << (w-1));
        rhi  = '0;
        rlo  = '0;
        case (fop)
            2'b00: begin
                p   = sa * sb;
                up  = 64'(p);
                rhi = 32'((up >> w) & mask);
                rlo = 32'(up & mask);
            end
            2'b01: begin
                up  = ua * ub;
                rhi = 32'((up >> w) & mask);
                rlo = 32'(up & mask);
            end
            2'b10: begin
                if (ub == 64'd0) begin
                    rlo = 32'(mask);
                    rhi = 32'(ua);
                end else if (sa == -msb && sb == -1) begin
                    rlo = 32'(ua);
                    rhi = '0;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    rlo = 32'(64'(q) & mask);
                    rhi = 32'(64'(r) & mask);
                end
            end
            default: begin
                if (ub == 64'd0) begin
                    rlo = 32'(mask);
                    rhi = 32'(ua);
                end else begin
                    rlo = 32'(ua / ub);
                    rhi = 32'(ua % ub);
                end
            end
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_done[k] = 1'b0;
            m_hi[k]   = '0;
            m_lo[k]   = '0;
            p_hi[k]   = '0;
            p_lo[k]   = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] wm;
            wm = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
            if (cancel) begin
                m_left[k] = 0;
                m_done[k] = 1'b0;
            end else if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
                m_done[k] = 1'b0;
                if (m_left[k] == 0) begin
                    m_hi[k]   = p_hi[k];
                    m_lo[k]   = p_lo[k];
                    m_done[k] = 1'b1;
                end
            end else begin
                m_done[k] = 1'b0;
                if (whi) m_hi[k] = wdata & wm;
                if (wlo) m_lo[k] = wdata & wm;
                if (start) begin
                    ref_calc(wid(k), op, a, b, p_hi[k], p_lo[k]);
                    m_left[k] = wid(k);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic wait_done32();
        int g;
        g = 0;
        while (!done32 && g < 100) begin
            tick();
            g++;
        end
        check("done32_reached", 32'(done32), 32'd1);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy32", 32'(busy32), 32'(m_left[0] > 0));
        check("done32", 32'(done32), 32'(m_done[0]));
        check("hi32",   hi32,        m_hi[0]);
        check("lo32",   lo32,        m_lo[0]);
        check("busy8",  32'(busy8),  32'(m_left[1] > 0));
        check("done8",  32'(done8),  32'(m_done[1]));
        check("hi8",    32'(hi8),    m_hi[1]);
        check("lo8",    32'(lo8),    m_lo[1]);
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h8000_0080;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] h, l;
    int          c32, c8, g;

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; whi = 1'b0; wlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        model_reset();

        // Pin the model with hand-computed results.
        ref_calc(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l);
        check("model_multu_hi", h, 32'hFFFF_FFFE);
        check("model_multu_lo", l, 32'h0000_0001);
        ref_calc(32, 2'b10, 32'hFFFF_FFF9, 32'd2, h, l);
        check("model_div_lo", l, 32'hFFFF_FFFD);
        check("model_div_hi", h, 32'hFFFF_FFFF);
        ref_calc(8, 2'b00, 32'h0000_00FD, 32'd7, h, l);
        check("model_mult8_lo", l, 32'h0000_00EB);
        check("model_mult8_hi", h, 32'h0000_00FF);
        ref_calc(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
        check("model_divovf_lo", l, 32'h8000_0000);
        check("model_divovf_hi", h, 32'h0000_0000);

        repeat (3) tick();
        check("rst_busy", 32'(busy32), 32'd0);
        check("rst_done", 32'(done32), 32'd0);
        check("rst_hi", hi32, 32'd0);
        check("rst_lo", lo32, 32'd0);
        #2 rst = 1'b0;

        // MULTU all-ones at both widths; start on the first edge after reset.
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        check("first_start_busy", 32'(busy32), 32'd1);
        c32 = 0; c8 = 0; g = 0;
        while (!done32 && g < 100) begin
            if (busy32) c32++;
            if (busy8)  c8++;
            tick();
            g++;
        end
        check("multu_done32", 32'(done32), 32'd1);
        check("multu_busy_cycles32", 32'(c32), 32'd32);
        check("multu_busy_cycles8", 32'(c8), 32'd8);
        check("multu_hi32", hi32, 32'hFFFF_FFFE);
        check("multu_lo32", lo32, 32'h0000_0001);
        check("multu_hi8", 32'(hi8), 32'h0000_00FE);
        check("multu_lo8", 32'(lo8), 32'h0000_0001);

        // MULT -3*7, then restart straight from DONE with DIV -7/2.
        tick();
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7;
        tick();
        start = 1'b0;
        wait_done32();
        check("mult_hi", hi32, 32'hFFFF_FFFF);
        check("mult_lo", lo32, 32'hFFFF_FFEB);
        start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
        tick();
        start = 1'b0;
        check("restart_busy", 32'(busy32), 32'd1);
        wait_done32();
        check("div_lo", lo32, 32'hFFFF_FFFD);
        check("div_hi", hi32, 32'hFFFF_FFFF);

        // Divide by zero and signed overflow.
        tick();
        start = 1'b1; op = 2'b11; a = 32'd5; b = 32'd0;
        tick();
        start = 1'b0;
        wait_done32();
        check("divz_lo", lo32, 32'hFFFF_FFFF);
        check("divz_hi", hi32, 32'h0000_0005);
        tick();
        start = 1'b1; op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        wait_done32();
        check("divovf_lo", lo32, 32'h8000_0000);
        check("divovf_hi", hi32, 32'h0000_0000);

        // Preload, start, ignored start during RUN, cancel on the 10th RUN edge.
        repeat (40) tick();
        whi = 1'b1; wdata = 32'h11;
        tick();
        whi = 1'b0; wlo = 1'b1; wdata = 32'h22;
        tick();
        wlo = 1'b0;
        check("preload_hi", hi32, 32'h0000_0011);
        check("preload_lo", lo32, 32'h0000_0022);
        start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", 32'(busy32), 32'd0);
        check("cancel_done", 32'(done32), 32'd0);
        check("cancel_hi", hi32, 32'h0000_0011);
        check("cancel_lo", lo32, 32'h0000_0022);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("cancel_no_done", 32'(done32), 32'd0);
        end

        // Asynchronous reset pulse between edges while running.
        start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #1 rst = 1'b1;
        #1;
        check("areset_busy32", 32'(busy32), 32'd0);
        check("areset_done32", 32'(done32), 32'd0);
        check("areset_hi32", hi32, 32'd0);
        check("areset_lo32", lo32, 32'd0);
        check("areset_busy8", 32'(busy8), 32'd0);
        check("areset_hi8", 32'(hi8), 32'd0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            tick();
            check("areset_no_done", 32'(done32), 32'd0);
        end

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            op     = 2'($urandom_range(0, 3));
            a      = pick();
            b      = pick();
            cancel = ($urandom_range(0, 39) == 0);
            whi    = !cancel && ($urandom_range(0, 7) == 0);
            wlo    = !cancel && ($urandom_range(0, 7) == 0);
            wdata  = $urandom;
            tick();
        end
        start = 1'b0; cancel = 1'b0; whi = 1'b0; wlo = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
